// File: rtl/mod_exp_ctrl_if.sv
// ============================================================================
// Module  : mod_exp_ctrl_if
// Brief   : Controller-to-modular-multiplier bus (operands, start, result).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mod_exp_ctrl_if #(
   parameter int NBITS = 4096
);
   logic             mul_enable_p;
   logic [NBITS-1:0] mul_a;
   logic [NBITS-1:0] mul_b;
   logic [NBITS-1:0] mul_m;
   logic [NBITS-1:0] mul_y;
   logic             mul_done_irq_p;

   modport master (
      output mul_enable_p,
      output mul_a,
      output mul_b,
      output mul_m,
      input  mul_y,
      input  mul_done_irq_p
   );

   modport slave (
      input  mul_enable_p,
      input  mul_a,
      input  mul_b,
      input  mul_m,
      output mul_y,
      output mul_done_irq_p
   );
endinterface

`default_nettype wire

// File: rtl/mod_exp_ctrl.sv
// ============================================================================
// Module  : mod_exp_ctrl
// Brief   : Left-to-right square-and-multiply sequencer driving an external
//           modular multiplier. Optional MOD_EXP_CONST_TIME_EN: multiply on
//           every exponent bit, discarding products for zero bits.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_exp_ctrl #(
   parameter int NBITS = 4096,
   parameter int EBITS = 4096
) (
   input  wire              clk,
   input  wire              rst_n,
   input  wire              start_p,
   input  wire [NBITS-1:0]  base,
   input  wire [EBITS-1:0]  exp,
   input  wire [NBITS-1:0]  m,
   output logic [NBITS-1:0] y,
   output logic             busy,
   output logic             done_irq_p,
   mod_exp_ctrl_if.master   mul
);

   localparam int               c_iw      = (EBITS > 1) ? $clog2(EBITS) : 1;
   localparam logic [c_iw-1:0]  c_idx_top = c_iw'(EBITS - 1);
   localparam logic [NBITS-1:0] c_one     = NBITS'(1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SQR_ISSUE = 3'd1,
      SQR_WAIT  = 3'd2,
      MUL_ISSUE = 3'd3,
      MUL_WAIT  = 3'd4,
      DONE      = 3'd5
   } state_t;

   state_t            r_state;
   state_t            w_state_nx;

   logic [NBITS-1:0]  r_base;
   logic [EBITS-1:0]  r_exp;
   logic [NBITS-1:0]  r_acc;
   logic [c_iw-1:0]   r_idx;
   logic [NBITS-1:0]  r_mul_a;
   logic [NBITS-1:0]  r_mul_b;
   logic [NBITS-1:0]  r_mul_m;
   logic              r_mul_en;

   logic              w_bit;
   logic              w_last;
   logic              w_take_mul;
   logic [NBITS-1:0]  w_mul_wait_acc;

   assign w_bit  = r_exp[r_idx];
   assign w_last = (r_idx == '0);

`ifdef MOD_EXP_CONST_TIME_EN
   // Always issue the multiply; the product is only kept for set bits.
   assign w_take_mul     = 1'b1;
   assign w_mul_wait_acc = w_bit ? mul.mul_y : r_acc;
`else
   assign w_take_mul     = w_bit;
   assign w_mul_wait_acc = mul.mul_y;
`endif

   assign mul.mul_enable_p = r_mul_en;
   assign mul.mul_a        = r_mul_a;
   assign mul.mul_b        = r_mul_b;
   assign mul.mul_m        = r_mul_m;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         IDLE: begin
            if (start_p) begin
               w_state_nx = SQR_ISSUE;
            end
         end
         SQR_ISSUE: begin
            w_state_nx = SQR_WAIT;
         end
         SQR_WAIT: begin
            if (mul.mul_done_irq_p) begin
               if (w_take_mul) begin
                  w_state_nx = MUL_ISSUE;
               end else if (w_last) begin
                  w_state_nx = DONE;
               end else begin
                  w_state_nx = SQR_ISSUE;
               end
            end
         end
         MUL_ISSUE: begin
            w_state_nx = MUL_WAIT;
         end
         MUL_WAIT: begin
            if (mul.mul_done_irq_p) begin
               w_state_nx = w_last ? DONE : SQR_ISSUE;
            end
         end
         DONE: begin
            w_state_nx = IDLE;
         end
         default: begin
            w_state_nx = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath and registered outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_base     <= '0;
         r_exp      <= '0;
         r_acc      <= '0;
         r_idx      <= '0;
         r_mul_a    <= '0;
         r_mul_b    <= '0;
         r_mul_m    <= '0;
         r_mul_en   <= 1'b0;
         y          <= '0;
         busy       <= 1'b0;
         done_irq_p <= 1'b0;
      end else begin
         r_mul_en   <= 1'b0;
         done_irq_p <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start_p) begin
                  r_base  <= base;
                  r_exp   <= exp;
                  r_mul_m <= m;
                  r_acc   <= c_one;
                  r_idx   <= c_idx_top;
                  busy    <= 1'b1;
               end
            end
            SQR_ISSUE: begin
               r_mul_a  <= r_acc;
               r_mul_b  <= r_acc;
               r_mul_en <= 1'b1;
            end
            SQR_WAIT: begin
               if (mul.mul_done_irq_p) begin
                  r_acc <= mul.mul_y;
                  // Bit advances here only when no multiply follows the square.
                  if (!w_take_mul && !w_last) begin
                     r_idx <= r_idx - 1'b1;
                  end
               end
            end
            MUL_ISSUE: begin
               r_mul_a  <= r_acc;
               r_mul_b  <= r_base;
               r_mul_en <= 1'b1;
            end
            MUL_WAIT: begin
               if (mul.mul_done_irq_p) begin
                  r_acc <= w_mul_wait_acc;
                  if (!w_last) begin
                     r_idx <= r_idx - 1'b1;
                  end
               end
            end
            DONE: begin
               y          <= r_acc;
               done_irq_p <= 1'b1;
               busy       <= 1'b0;
            end
            default: begin
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mod_exp_ctrl.sv
// ============================================================================
// Module  : tb_mod_exp_ctrl
// Brief   : Bench for mod_exp_ctrl with a behavioural variable-latency
//           modular multiplier and a scoreboard of expected results.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mod_exp_ctrl;

   localparam int NB = 8;
   localparam int EB = 8;

   logic          clk     = 1'b0;
   logic          rst_n   = 1'b0;
   logic          start_p = 1'b0;
   logic [NB-1:0] base    = '0;
   logic [EB-1:0] exp     = '0;
   logic [NB-1:0] m       = '0;
   wire  [NB-1:0] y;
   wire           busy;
   wire           done_irq_p;

   int errors = 0;
   int checks = 0;

   mod_exp_ctrl_if #(.NBITS(NB)) mif ();

   mod_exp_ctrl #(.NBITS(NB), .EBITS(EB)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_p    (start_p),
      .base       (base),
      .exp        (exp),
      .m          (m),
      .y          (y),
      .busy       (busy),
      .done_irq_p (done_irq_p),
      .mul        (mif)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Right-to-left reference, independent of the controller's bit order.
   function automatic logic [NB-1:0] ref_modexp(input logic [NB-1:0] b, input logic [EB-1:0] e,
                                                input logic [NB-1:0] md);
      int r  = 1;
      int bb = int'(b);
      for (int i = 0; i < EB; i++) begin
         if (e[i]) r = (r * bb) % int'(md);
         bb = (bb * bb) % int'(md);
      end
      return NB'(r % int'(md));
   endfunction

   // Behavioural modular multiplier with random latency.
   int            en_count = 0;
   int            overlap  = 0;
   logic          mbusy;
   logic [2:0]    mcnt;
   logic [NB-1:0] ma, mb, mm;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mbusy              <= 1'b0;
         mcnt               <= '0;
         ma                 <= '0;
         mb                 <= '0;
         mm                 <= '0;
         mif.mul_y          <= '0;
         mif.mul_done_irq_p <= 1'b0;
      end else begin
         mif.mul_done_irq_p <= 1'b0;
         if (mif.mul_enable_p) begin
            en_count <= en_count + 1;
            if (mbusy) overlap <= overlap + 1;
            ma    <= mif.mul_a;
            mb    <= mif.mul_b;
            mm    <= mif.mul_m;
            mcnt  <= 3'($urandom_range(0, 4));
            mbusy <= 1'b1;
         end else if (mbusy) begin
            if (mcnt == 0) begin
               mif.mul_y          <= NB'((int'(ma) * int'(mb)) % int'(mm));
               mif.mul_done_irq_p <= 1'b1;
               mbusy              <= 1'b0;
            end else begin
               mcnt <= mcnt - 1'b1;
            end
         end
      end
   end

   // Scoreboard: every completion pulse pops one expected result.
   logic [NB-1:0] sb[$];
   int            done_count = 0;

   always @(negedge clk) begin
      if (rst_n === 1'b1 && done_irq_p === 1'b1) begin
         done_count++;
         if (sb.size() == 0) begin
            check("unexpected_done", 32'(done_irq_p), 32'(0));
         end else begin
            logic [NB-1:0] ey;
            ey = sb.pop_front();
            check("y", 32'(y), 32'(ey));
         end
      end
   end

   // Caller must be at a negedge; start is driven immediately.
   task automatic run(input logic [NB-1:0] b, input logic [EB-1:0] e, input logic [NB-1:0] md,
                      input bit repulse);
      int            e0, d0, cyc, npulse;
      logic [NB-1:0] ey;
      ey = ref_modexp(b, e, md);
`ifdef MOD_EXP_CONST_TIME_EN
      npulse = 2 * EB;
`else
      npulse = EB + $countones(e);
`endif
      base = b; exp = e; m = md; start_p = 1'b1;
      sb.push_back(ey);
      e0 = en_count;
      d0 = done_count;
      @(negedge clk);
      start_p = 1'b0;
      check("busy_on", 32'(busy), 32'(1));
      check("mul_m", 32'(mif.mul_m), 32'(md));
      if (repulse) begin
         repeat (6) @(negedge clk);
         base = 8'd2; exp = 8'd8; m = 8'd251; start_p = 1'b1;
         @(negedge clk);
         start_p = 1'b0;
         check("mul_m_hold", 32'(mif.mul_m), 32'(md));
      end
      cyc = 0;
      while (done_irq_p !== 1'b1 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      check("timeout", 32'(cyc < 2000), 32'(1));
      check("busy_off", 32'(busy), 32'(0));
      @(negedge clk);
      check("done_pulses", 32'(done_count - d0), 32'(1));
      check("mul_pulses", 32'(en_count - e0), 32'(npulse));
      repeat (3) @(negedge clk);
      check("y_hold", 32'(y), 32'(ey));
   endtask

   initial begin
      int cyc;
      int d0;

      repeat (2) @(negedge clk);
      check("rst_y", 32'(y), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done_irq_p), 32'(0));
      check("rst_mul_en", 32'(mif.mul_enable_p), 32'(0));
      check("rst_mul_a", 32'(mif.mul_a), 32'(0));
      check("rst_mul_b", 32'(mif.mul_b), 32'(0));
      check("rst_mul_m", 32'(mif.mul_m), 32'(0));

      rst_n = 1'b1;
      run(8'd3, 8'd5, 8'd13, 1'b0);
      check("y_3_5_13", 32'(y), 32'(9));
      @(negedge clk);
      run(8'd2, 8'd8, 8'd251, 1'b0);
      check("y_2_8_251", 32'(y), 32'(5));
      @(negedge clk);
      run(8'd12, 8'd2, 8'd13, 1'b0);
      check("y_12_2_13", 32'(y), 32'(1));
      @(negedge clk);
      run(8'd7, 8'd0, 8'd13, 1'b0);
      check("y_exp0", 32'(y), 32'(1));
      @(negedge clk);
      run(8'd0, 8'd7, 8'd13, 1'b0);
      check("y_base0", 32'(y), 32'(0));
      @(negedge clk);
      run(8'd3, 8'd5, 8'd13, 1'b1);
      check("y_repulse", 32'(y), 32'(9));

      // Abort during SQR_WAIT: first enable pulse is visible only in that state.
      @(negedge clk);
      base = 8'd3; exp = 8'd5; m = 8'd13; start_p = 1'b1;
      @(negedge clk);
      start_p = 1'b0;
      cyc = 0;
      while (mif.mul_enable_p !== 1'b1 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("sqr_wait_seen", 32'(cyc < 50), 32'(1));
      d0 = done_count;
      #2 rst_n = 1'b0;
      #1;
      check("arst_y", 32'(y), 32'(0));
      check("arst_busy", 32'(busy), 32'(0));
      check("arst_mul_en", 32'(mif.mul_enable_p), 32'(0));
      check("arst_mul_a", 32'(mif.mul_a), 32'(0));
      check("arst_mul_b", 32'(mif.mul_b), 32'(0));
      check("arst_mul_m", 32'(mif.mul_m), 32'(0));
      repeat (5) @(negedge clk);
      check("arst_no_done", 32'(done_count - d0), 32'(0));
      rst_n = 1'b1;
      run(8'd3, 8'd5, 8'd13, 1'b0);
      check("y_after_rst", 32'(y), 32'(9));

      check("mul_overlap", 32'(overlap), 32'(0));
      check("sb_empty", 32'(sb.size()), 32'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mod_exp_ctrl.md
MOD_EXP_CTRL -- requirements
Module: mod_exp_ctrl

Interface
REQ-001 SHALL have parameter NBITS, default 4096, operand/modulus width; must match the attached multiplier.
REQ-002 SHALL have parameter EBITS, default 4096, exponent width.
REQ-003 SHALL have ports: clk  input  1  single clock, rising edge.
REQ-004 SHALL have ports: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: start_p  input  1  one-cycle start pulse.
REQ-006 SHALL have ports: base  input  NBITS  base; precondition base < m.
REQ-007 SHALL have ports: exp  input  EBITS  exponent.
REQ-008 SHALL have ports: m  input  NBITS  modulus; precondition m >= 2; result undefined otherwise.
REQ-009 SHALL have ports: y  output  NBITS  result base^exp mod m.
REQ-010 SHALL have ports: busy  output  1  high while an exponentiation runs.
REQ-011 SHALL have ports: done_irq_p  output  1  one-cycle completion pulse.
REQ-012 SHALL have ports: mul_enable_p  output  1  start pulse to the modular multiplier.
REQ-013 SHALL have ports: mul_a, mul_b, mul_m  output  NBITS each  multiplier operands and modulus, registered.
REQ-014 SHALL have ports: mul_y  input  NBITS  multiplier product.
REQ-015 SHALL have ports: mul_done_irq_p  input  1  multiplier completion pulse.

Function
REQ-016 SHALL compute y = base^exp mod m by left-to-right square-and-multiply over all EBITS exponent bits, MSB first, with acc initialised to 1 and no leading-zero skipping.
REQ-017 SHALL use states IDLE, SQR_ISSUE, SQR_WAIT, MUL_ISSUE, MUL_WAIT, DONE.
REQ-018 In IDLE, start_p SHALL latch base, exp and m, set acc=1 and bit index to EBITS-1, assert busy, and go to SQR_ISSUE.
REQ-019 In SQR_ISSUE, the block SHALL drive mul_a=mul_b=acc and pulse mul_enable_p for exactly one cycle, then go to SQR_WAIT.
REQ-020 In SQR_WAIT, on mul_done_irq_p the block SHALL set acc=mul_y; it SHALL go to MUL_ISSUE if exp[idx]=1, otherwise advance the bit.
REQ-021 In MUL_ISSUE, the block SHALL drive mul_a=acc and mul_b=base, pulse mul_enable_p, then go to MUL_WAIT.
REQ-022 In MUL_WAIT, on mul_done_irq_p the block SHALL set acc=mul_y, then advance the bit.
REQ-023 Advance SHALL mean: if idx=0 go to DONE, else decrement idx and go to SQR_ISSUE; each issue state is entered on the cycle after the pulse.
REQ-024 In DONE, the block SHALL register y=acc, pulse done_irq_p for one cycle, deassert busy in the same cycle, and return to IDLE.
REQ-025 y SHALL hold its value until the next DONE.
REQ-026 start_p while busy SHALL be ignored.
REQ-027 start_p in the DONE cycle SHALL be ignored.
REQ-028 mul_done_irq_p outside the WAIT states SHALL be ignored.
REQ-029 mul_enable_p SHALL never be asserted while a multiply is outstanding.
REQ-030 mul_m SHALL equal the latched m throughout busy.
REQ-031 exp=0 SHALL yield y=1.
REQ-032 base=0 with exp!=0 SHALL yield y=0.

Reset
REQ-033 rst_n low SHALL asynchronously force IDLE, with y=0, acc=0, busy=0, done_irq_p=0, mul_enable_p=0, and mul_a=mul_b=mul_m=0.
REQ-034 Reset mid-operation SHALL abort with no done_irq_p pulse.
REQ-035 After reset, the block SHALL accept start_p on the first cycle after rst_n rises.

Configuration
REQ-036 Macro MOD_EXP_CONST_TIME_EN, when defined, SHALL enter MUL_ISSUE for every bit; in MUL_WAIT acc SHALL take mul_y only when exp[idx]=1, otherwise keep its value; total multiplies SHALL be exactly 2*EBITS.
REQ-037 Without MOD_EXP_CONST_TIME_EN, the block SHALL enter MUL_ISSUE only when exp[idx]=1; total multiplies SHALL be EBITS + popcount(exp).

Verification (NBITS=8, EBITS=8, real multiplier attached)
REQ-038 SHALL cover: base=3, exp=5, m=13 -> y=9, single done_irq_p; 10 mul_enable_p pulses (16 with MOD_EXP_CONST_TIME_EN).
REQ-039 SHALL cover: base=2, exp=8, m=251 -> y=5.
REQ-040 SHALL cover: base=12, exp=2, m=13 -> y=1; then base=7, exp=0, m=13 -> y=1.
REQ-041 SHALL cover: base=0, exp=7, m=13 -> y=0.
REQ-042 SHALL cover: start_p re-pulsed mid-run with different operands -> ignored; the original result is still produced.
REQ-043 SHALL cover: rst_n low during SQR_WAIT -> outputs zero immediately, no done_irq_p; a following start with base=3, exp=5, m=13 -> y=9.
